// File: rtl/assoc_set.sv
// Set-associative cache set: WAYS ways of WORDS words with tag, valid, dirty and LRU age per way.
// Each request is latched in IDLE, resolved in LOOKUP and acknowledged in DONE.
module assoc_set #(
  parameter int WAYS   = 2,
  parameter int WORDS  = 4,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     comp,
  input  logic                     write,
  input  logic [$clog2(WORDS)-1:0] word,
  input  logic [$clog2(WAYS)-1:0]  way_sel,
  input  logic [TAG_W-1:0]         tag_in,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     valid_in,
  output logic                     hit,
  output logic                     dirty_out,
  output logic                     valid_out,
  output logic [TAG_W-1:0]         tag_out,
  output logic [DATA_W-1:0]        data_out,
  output logic [$clog2(WAYS)-1:0]  way_out,
  output logic                     ack
);

  // state  | meaning
  // IDLE   | waiting for enable; request fields latched on accept
  // LOOKUP | tags compared, storage and ages updated, responses registered
  // DONE   | ack high for one cycle
  localparam int WW = $clog2(WAYS);
  localparam int BW = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE = 2'd0, LOOKUP = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_nx;

  logic              r_comp, r_write, r_valid;
  logic [BW-1:0]     r_word;
  logic [WW-1:0]     r_way;
  logic [TAG_W-1:0]  r_tag;
  logic [DATA_W-1:0] r_data;

  logic [TAG_W-1:0]  tag_mem  [WAYS];
  logic [DATA_W-1:0] data_mem [WAYS*WORDS];
  logic [WAYS-1:0]   valid_q, dirty_q;
  logic [WW-1:0]     age_q    [WAYS];

  logic              hit_any, inv_any, do_write, do_touch;
  logic [WW-1:0]     hit_way, inv_way, old_way, victim, sel_way;
  logic [WW+BW-1:0]  addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (enable) state_nx = LOOKUP;
      LOOKUP:  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ack = (state == DONE);
  end

  // Descending scans so the lowest matching index is the one that sticks.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    old_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (valid_q[i] && tag_mem[i] == r_tag) begin
        hit_any = 1'b1;
        hit_way = WW'(i);
      end
      if (!valid_q[i]) begin
        inv_any = 1'b1;
        inv_way = WW'(i);
      end
      if (age_q[i] == WW'(WAYS - 1)) old_way = WW'(i);
    end
    victim   = inv_any ? inv_way : old_way;
    sel_way  = r_comp ? (hit_any ? hit_way : victim) : r_way;
    addr     = {sel_way, r_word};
    do_write = r_write && (!r_comp || hit_any);
    do_touch = r_comp ? hit_any : r_write;
  end

  // Tag and data arrays survive reset; the rst gate keeps an abandoned op from writing.
  always_ff @(posedge clk) begin
    if (!rst && state == LOOKUP && do_write) begin
      data_mem[addr] <= r_data;
      if (!r_comp) tag_mem[sel_way] <= r_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_comp    <= 1'b0;
      r_write   <= 1'b0;
      r_valid   <= 1'b0;
      r_word    <= '0;
      r_way     <= '0;
      r_tag     <= '0;
      r_data    <= '0;
      valid_q   <= '0;
      dirty_q   <= '0;
      for (int i = 0; i < WAYS; i++) age_q[i] <= WW'(i);
      hit       <= 1'b0;
      dirty_out <= 1'b0;
      valid_out <= 1'b0;
      tag_out   <= '0;
      data_out  <= '0;
      way_out   <= '0;
    end else begin
      if (state == IDLE && enable) begin
        r_comp  <= comp;
        r_write <= write;
        r_valid <= valid_in;
        r_word  <= word;
        r_way   <= way_sel;
        r_tag   <= tag_in;
        r_data  <= data_in;
      end
      if (state == LOOKUP) begin
        hit       <= r_comp && hit_any;
        way_out   <= sel_way;
        tag_out   <= tag_mem[sel_way];
        valid_out <= valid_q[sel_way];
        dirty_out <= dirty_q[sel_way];
        data_out  <= data_mem[addr];
        if (do_write) begin
          if (r_comp) begin
            dirty_q[sel_way] <= 1'b1;
          end else begin
            valid_q[sel_way] <= r_valid;
            dirty_q[sel_way] <= 1'b0;
          end
        end
        if (do_touch) begin
          for (int j = 0; j < WAYS; j++) begin
            if (WW'(j) == sel_way)            age_q[j] <= '0;
            else if (age_q[j] < age_q[sel_way]) age_q[j] <= age_q[j] + 1'b1;
          end
        end
      end
    end
  end

endmodule
